// File: rtl/mem_access_unit.sv
// Load/store front end between the ALU and the word-only data memory dm.
// Define MAU_SUBWORD_EN to build byte/half loads and read-modify-write sub-word stores.
module mem_access_unit #(
    parameter int DM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] result,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [31:0] dm_rdata,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic        dm_we,
    output logic        dm_re,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        mem_err,
    output logic [31:0] err_addr
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LD = 2'd1, S_RMW = 2'd2} state_e;

    localparam logic [1:0]  SZ_BYTE  = 2'b00;
    localparam logic [1:0]  SZ_HALF  = 2'b01;
    localparam logic [1:0]  SZ_WORD  = 2'b10;
    localparam logic [1:0]  SZ_BAD   = 2'b11;
    localparam logic [31:0] DM_LIMIT = DM_WORDS;

    state_e      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic [31:0] word_idx;
    logic [31:0] ld_value;
    logic        req, reject;
    logic        we_c, re_c, stall_c, err_c;

    assign word_idx = {2'b00, result[31:2]};
    assign dm_addr  = word_idx;
    assign req      = MemRead | MemWrite;

`ifdef MAU_SUBWORD_EN
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] st_merged;
    logic        sub_access;

    assign lane_b     = dm_rdata[{result[1:0], 3'b000} +: 8];
    assign lane_h     = dm_rdata[{result[1], 4'b0000} +: 16];
    assign sub_access = (size == SZ_BYTE) || (size == SZ_HALF);
    assign reject     = (MemRead && MemWrite) || (size == SZ_BAD)
                     || (size == SZ_HALF && result[0])
                     || (size == SZ_WORD && result[1:0] != 2'b00)
                     || (word_idx >= DM_LIMIT);

    always_comb begin
        ld_value = dm_rdata;
        case (size)
            SZ_BYTE: ld_value = ld_unsigned ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_HALF: ld_value = ld_unsigned ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: ld_value = dm_rdata;
        endcase
    end

    always_comb begin
        st_merged = dm_rdata;
        if (size == SZ_BYTE) begin
            st_merged[{result[1:0], 3'b000} +: 8] = WriteData[7:0];
        end else if (size == SZ_HALF) begin
            st_merged[{result[1], 4'b0000} +: 16] = WriteData[15:0];
        end
    end
`else
    logic unused_cfg;

    // Without sub-word support every access is a word access.
    assign unused_cfg = ^{size, ld_unsigned};
    assign reject     = (MemRead && MemWrite) || (result[1:0] != 2'b00)
                     || (word_idx >= DM_LIMIT);
    assign ld_value   = dm_rdata;
`endif

    // NOTE: every output and next-state value gets a default first, so no latches are inferred.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        err_addr_d = err_addr_q;
        we_c       = 1'b0;
        re_c       = 1'b0;
        stall_c    = 1'b0;
        err_c      = 1'b0;
        dm_wdata   = WriteData;
        load_data  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (reject) begin
                        err_c      = 1'b1;
                        err_addr_d = result;
                    end else if (MemRead) begin
                        re_c    = 1'b1;
                        stall_c = 1'b1;
                        state_d = S_LD;
`ifdef MAU_SUBWORD_EN
                    end else if (sub_access) begin
                        re_c    = 1'b1;
                        stall_c = 1'b1;
                        state_d = S_RMW;
`endif
                    end else begin
                        we_c = 1'b1;
                    end
                end
            end
            S_LD: begin
                load_data = ld_value;
                hold_d    = ld_value;
                state_d   = S_IDLE;
            end
`ifdef MAU_SUBWORD_EN
            S_RMW: begin
                dm_wdata = st_merged;
                we_c     = 1'b1;
                state_d  = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are forced low while reset is held, even though IDLE decodes live inputs.
    assign dm_we   = we_c & ~rst;
    assign dm_re   = re_c & ~rst;
    assign stall   = stall_c & ~rst;
    assign mem_err = err_c & ~rst;
    assign err_addr = err_addr_q;

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            err_addr_q <= err_addr_d;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: word-only dm model, reference memory and load/store scoreboard.
// Expectations follow the MAU_SUBWORD_EN setting of the build.
module tb_mem_access_unit;
    localparam int DM_WORDS = 1024;

    logic        clk, rst;
    logic [31:0] result, WriteData, dm_rdata;
    logic        MemRead, MemWrite, ld_unsigned;
    logic [1:0]  size;
    logic [31:0] dm_addr, dm_wdata, load_data, err_addr;
    logic        dm_we, dm_re, stall, mem_err;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem [DM_WORDS];
    logic [31:0] dm_mem  [DM_WORDS];
    logic        tb_load;

    mem_access_unit #(.DM_WORDS(DM_WORDS)) dut (
        .clk(clk), .rst(rst), .result(result), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .size(size), .ld_unsigned(ld_unsigned),
        .dm_rdata(dm_rdata), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we),
        .dm_re(dm_re), .load_data(load_data), .stall(stall), .mem_err(mem_err),
        .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i * 32'h0101_0101) ^ 32'hA5C3_0F96;
    endfunction

    // Behavioural dm: synchronous write, read data valid the cycle after dm_re.
    always @(posedge clk) begin
        if (tb_load) begin
            for (int i = 0; i < DM_WORDS; i++) dm_mem[i] <= init_word(i);
        end else if (dm_we) begin
            dm_mem[dm_addr[9:0]] <= dm_wdata;
        end
        if (dm_re) dm_rdata <= dm_mem[dm_addr[9:0]];
    end

    function automatic bit model_reject(input logic rd, input logic wr,
                                        input logic [31:0] a, input logic [1:0] sz);
        if (rd && wr) return 1'b1;
        if ((a >> 2) >= DM_WORDS) return 1'b1;
`ifdef MAU_SUBWORD_EN
        case (sz)
            2'b11:   return 1'b1;
            2'b01:   return (a % 2) != 0;
            2'b10:   return (a % 4) != 0;
            default: return 1'b0;
        endcase
`else
        return (a % 4) != 0 || sz === 2'bxx;
`endif
    endfunction

    function automatic bit model_subword(input logic [1:0] sz);
`ifdef MAU_SUBWORD_EN
        return sz == 2'b00 || sz == 2'b01;
`else
        return sz === 2'bxx;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                               input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        v = w;
`ifdef MAU_SUBWORD_EN
        if (sz == 2'b00) begin
            v = (w >> (8 * (a % 4))) & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end
`endif
        return v;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [31:0] a,
                                                input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] mask;
        int          sh;
        if (sz == 2'b00) begin
            sh   = 8 * int'(a % 4);
            mask = 32'h0000_00FF << sh;
        end else begin
            sh   = 16 * int'((a / 2) % 2);
            mask = 32'h0000_FFFF << sh;
        end
        return (w & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic idle_inputs();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    // Called just after a posedge; returns just after the posedge that ends the access.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                             input string tag);
        logic [31:0] exp_v, last_load;
        int          idx;
        bit          rej;
        rej = model_reject(rd, wr, a, sz);
        idx = int'(a[11:2]);
        MemRead = rd; MemWrite = wr; result = a; size = sz; ld_unsigned = uns; WriteData = wd;
        @(negedge clk);
        if (rej) begin
            total_cnt++; if (mem_err !== 1'b1) $display("FAIL %s mem_err: got %b want 1", tag, mem_err); else pass_cnt++;
            total_cnt++; if ({stall, dm_re, dm_we} !== 3'b000) $display("FAIL %s stall/re/we: got %b want 000", tag, {stall, dm_re, dm_we}); else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++; if (err_addr !== a) $display("FAIL %s err_addr: got %h want %h", tag, err_addr, a); else pass_cnt++;
        end else if (wr && !model_subword(sz)) begin
            total_cnt++; if ({dm_we, stall, mem_err} !== 3'b100) $display("FAIL %s we/stall/err: got %b want 100", tag, {dm_we, stall, mem_err}); else pass_cnt++;
            total_cnt++; if (dm_addr !== (a >> 2)) $display("FAIL %s dm_addr: got %h want %h", tag, dm_addr, a >> 2); else pass_cnt++;
            total_cnt++; if (dm_wdata !== wd) $display("FAIL %s dm_wdata: got %h want %h", tag, dm_wdata, wd); else pass_cnt++;
            ref_mem[idx] = wd;
            @(posedge clk); #1;
        end else begin
            total_cnt++; if ({stall, dm_re, dm_we} !== 3'b110) $display("FAIL %s first cycle stall/re/we: got %b want 110", tag, {stall, dm_re, dm_we}); else pass_cnt++;
            if (rd) exp_q.push_back(model_load(ref_mem[idx], a, sz, uns));
            else    exp_q.push_back(model_merge(ref_mem[idx], a, sz, wd));
            @(posedge clk);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            total_cnt++; if (stall !== 1'b0) $display("FAIL %s second cycle stall: got %b want 0", tag, stall); else pass_cnt++;
            if (rd) begin
                total_cnt++; if (load_data !== exp_v) $display("FAIL %s load_data: got %h want %h", tag, load_data, exp_v); else pass_cnt++;
                last_load = exp_v;
                @(posedge clk); #1;
                total_cnt++; if (load_data !== last_load) $display("FAIL %s load hold: got %h want %h", tag, load_data, last_load); else pass_cnt++;
            end else begin
                total_cnt++; if (dm_we !== 1'b1) $display("FAIL %s rmw dm_we: got %b want 1", tag, dm_we); else pass_cnt++;
                total_cnt++; if (dm_wdata !== exp_v) $display("FAIL %s rmw dm_wdata: got %h want %h", tag, dm_wdata, exp_v); else pass_cnt++;
                ref_mem[idx] = exp_v;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b1; size = 2'b10; result = 32'h20;
        WriteData = 32'h1234_5678; ld_unsigned = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++; if ({dm_we, dm_re, stall, mem_err} !== 4'b0000) $display("FAIL reset strobes: got %b want 0000", {dm_we, dm_re, stall, mem_err}); else pass_cnt++;
        total_cnt++; if (load_data !== 32'h0) $display("FAIL reset load_data: got %h want 0", load_data); else pass_cnt++;
        total_cnt++; if (err_addr !== 32'h0) $display("FAIL reset err_addr: got %h want 0", err_addr); else pass_cnt++;
        MemRead = 1'b1;
        #1;
        total_cnt++; if ({mem_err, dm_re} !== 2'b00) $display("FAIL reset conflict err/re: got %b want 00", {mem_err, dm_re}); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0; tb_load = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        do_access(1'b0, 1'b1, 32'h20, 2'b10, 1'b0, 32'h8000_00F0, "word_store");
        do_access(1'b1, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, "word_load");
    endtask

    task automatic test_subword();
`ifdef MAU_SUBWORD_EN
        do_access(1'b1, 1'b0, 32'h20, 2'b00, 1'b0, 32'h0, "byte_load_s");
        do_access(1'b1, 1'b0, 32'h20, 2'b00, 1'b1, 32'h0, "byte_load_u");
        do_access(1'b1, 1'b0, 32'h22, 2'b01, 1'b0, 32'h0, "half_load_s");
        do_access(1'b0, 1'b1, 32'h21, 2'b00, 1'b0, 32'h0000_00AB, "byte_store");
        do_access(1'b1, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, "word_after_byte");
        do_access(1'b0, 1'b1, 32'h26, 2'b01, 1'b0, 32'hFFFF_7E81, "half_store");
        do_access(1'b1, 1'b0, 32'h26, 2'b01, 1'b1, 32'h0, "half_load_u");
`else
        do_access(1'b0, 1'b1, 32'h24, 2'b00, 1'b0, 32'hCAFE_0042, "bytesize_store");
        do_access(1'b1, 1'b0, 32'h24, 2'b01, 1'b0, 32'h0, "halfsize_load");
`endif
    endtask

    task automatic test_errors();
`ifdef MAU_SUBWORD_EN
        do_access(1'b1, 1'b0, 32'h23, 2'b01, 1'b0, 32'h0, "err_half_odd");
`else
        do_access(1'b1, 1'b0, 32'h23, 2'b00, 1'b0, 32'h0, "err_unaligned");
`endif
        idle_inputs();
        @(negedge clk);
        total_cnt++; if (mem_err !== 1'b0) $display("FAIL err pulse width: got %b want 0", mem_err); else pass_cnt++;
        @(posedge clk); #1;
        do_access(1'b1, 1'b0, 32'h1000, 2'b10, 1'b0, 32'h0, "err_range");
        do_access(1'b1, 1'b1, 32'h30, 2'b10, 1'b0, 32'h0, "err_both");
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        MemRead = 1'b1; MemWrite = 1'b0; result = 32'h20; size = 2'b10;
        @(negedge clk);
        total_cnt++; if (stall !== 1'b1) $display("FAIL rst_ld first stall: got %b want 1", stall); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total_cnt++; if ({stall, load_data, err_addr} !== 65'h0) $display("FAIL rst_ld stall/load/err: got %b %h %h want 0 0 0", stall, load_data, err_addr); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0; idle_inputs();
        @(posedge clk); #1;
`ifdef MAU_SUBWORD_EN
        do_access(1'b0, 1'b1, 32'h24, 2'b10, 1'b0, 32'h1122_3344, "pre_rmw_store");
        MemRead = 1'b0; MemWrite = 1'b1; result = 32'h24; size = 2'b00; WriteData = 32'h5A;
        @(negedge clk);
        total_cnt++; if ({stall, dm_re} !== 2'b11) $display("FAIL rst_rmw first stall/re: got %b want 11", {stall, dm_re}); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total_cnt++; if (dm_we !== 1'b0) $display("FAIL rst_rmw dm_we: got %b want 0", dm_we); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (dm_mem[9] !== ref_mem[9]) $display("FAIL rst_rmw mem[9]: got %h want %h", dm_mem[9], ref_mem[9]); else pass_cnt++;
        rst = 1'b0; idle_inputs();
        @(negedge clk);
        total_cnt++; if ({stall, load_data} !== 33'h0) $display("FAIL rst_rmw stall/load_data: got %b %h want 0 0", stall, load_data); else pass_cnt++;
        @(posedge clk); #1;
        do_access(1'b1, 1'b0, 32'h24, 2'b10, 1'b0, 32'h0, "after_rst_rmw");
`endif
        do_access(1'b1, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, "after_rst_ld");
    endtask

    // Requests issued with no idle cycle between them, including right after LD/RMW.
    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            int          r;
            logic        rd, wr;
            logic [31:0] a;
            r  = int'($urandom_range(0, 15));
            rd = r[0];
            wr = ~r[0];
            if (r == 15) wr = 1'b1;
            a  = (r == 14) ? 32'h1000 + $urandom_range(0, 7) : 32'($urandom_range(0, 63));
            do_access(rd, wr, a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, "b2b");
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; tb_load = 1'b1;
        idle_inputs();
        result = '0; WriteData = '0; size = 2'b10; ld_unsigned = 1'b0;
        for (int i = 0; i < DM_WORDS; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end placed between the ALU and the data memory `dm`. It converts byte addresses from the ALU `result` into `dm` word indices, and adds byte and halfword loads with sign or zero extension. It performs byte and halfword stores as read-modify-write sequences on the word-only `dm`. It stalls the datapath while a multi-cycle access is in flight and flags illegal accesses instead of issuing them.

## Interface
Parameters:
- DM_WORDS, 1024: number of 32-bit words in `dm`. Valid word index is 0..DM_WORDS-1.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- result  in  32  byte address from the ALU.
- WriteData  in  32  store data; the sub-word value is in the low bits.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- ld_unsigned  in  1  1 = zero-extend the load, 0 = sign-extend.
- dm_rdata  in  32  `dm` ReadData, valid the cycle after dm_re.
- dm_addr  out  32  word index to `dm`, equal to {2'b00, result[31:2]}.
- dm_wdata  out  32  write data to `dm`.
- dm_we  out  1  `dm` MemWrite.
- dm_re  out  1  `dm` MemRead.
- load_data  out  32  extended load result.
- stall  out  1  datapath must hold the instruction and all request inputs.
- mem_err  out  1  one-cycle pulse when a request is rejected.
- err_addr  out  32  `result` captured on the most recent rejected request.

## Operation
- Request definitions:
  - A request exists when `MemRead | MemWrite`.
  - A request is rejected when any of the following holds:
    - MemRead and MemWrite are both high.
    - size == 11.
    - A half access has result[0] = 1.
    - A word access has result[1:0] != 0.
    - The word index is >= DM_WORDS.
- Rejected request, evaluated in IDLE only:
  - mem_err = 1 and dm_we = dm_re = stall = 0.
  - err_addr <= result at the clock edge.
- States: IDLE, LD, RMW.
- IDLE, word store: dm_we = 1 and dm_wdata = WriteData. No stall. Next state is IDLE.
- IDLE, any load: dm_re = 1 and stall = 1. Next state is LD.
- IDLE, byte or half store: dm_re = 1 and stall = 1. Next state is RMW.
- LD: extract the lane from dm_rdata, extend it, and drive load_data combinationally. stall = 0. load_data is also latched into a hold register at the edge. Next state is IDLE.
- RMW: merge the lane of WriteData into dm_rdata and drive dm_wdata. dm_we = 1 and stall = 0. Next state is IDLE.
- Lane selection is little-endian:
  - Byte lane n = result[1:0] occupies bits 8n+7:8n.
  - Half lane h = result[1] occupies bits 16h+15:16h.
- Extension:
  - ld_unsigned = 0 replicates bit 7 (byte) or bit 15 (half) into the upper bits.
  - ld_unsigned = 1 fills the upper bits with zeros.
  - Word loads pass through unchanged.
- load_data source: in the LD state it is the live extracted value. In every other state it is the hold register.
- Request inputs that change while stall = 1 are a protocol violation and are not checked.

## Timing
- Latency:
  - Word store: 1 cycle, 0 stall cycles.
  - Load, or byte/half store: 2 cycles, stall high in the first cycle only.
- The `dm` write for a sub-word store happens at the posedge ending the RMW cycle.
- Reset values:
  - State = IDLE.
  - load_data hold = 0, err_addr = 0.
  - dm_we, dm_re, stall and mem_err = 0 while rst is high, regardless of inputs.
- Reset asserted in LD or RMW:
  - The access is abandoned immediately and no `dm` write is issued.
  - After release the unit is in IDLE and re-evaluates whatever request is present.
- There are no back-to-back constraints. A new request may be presented in the cycle right after LD or RMW.

## Configuration
- MAU_SUBWORD_EN defined:
  - Full byte/half support as described above.
- MAU_SUBWORD_EN undefined:
  - The RMW state and the lane/extension logic are not built.
  - size and ld_unsigned are ignored, and every access is treated as a word access.
  - The alignment check is result[1:0] != 0.
  - Loads still take 2 cycles via LD. All stores take 1 cycle.

## Test plan
- Word store and load:
  - Word store 0x8000_00F0 to address 0x20 -> dm_we = 1 and dm_addr = 8 in the same cycle, stall = 0.
  - Word load from 0x20 -> stall for 1 cycle, then load_data = 0x8000_00F0.
- Byte loads from 0x20, after the store above:
  - Signed -> 0xFFFF_FFF0.
  - Unsigned -> 0x0000_00F0.
- Half load:
  - Signed half load from 0x22 -> 0xFFFF_8000.
- Byte store 0xAB to 0x21:
  - Cycle 0: stall = 1, dm_re = 1.
  - Cycle 1: dm_we = 1, dm_wdata = 0x8000_ABF0.
  - A subsequent word load from 0x20 returns 0x8000_ABF0.
- Rejected requests:
  - Half load from 0x23 -> mem_err pulse, err_addr = 0x23, no dm_re, no stall.
  - Word load from 0x1000 (index 1024) -> mem_err pulse.
  - MemRead = MemWrite = 1 -> mem_err pulse.
- Reset during RMW:
  - Assert rst in the RMW cycle of a byte store to 0x24 -> dm_we stays 0 and mem[9] is unchanged.
  - After release, load_data = 0 and state is IDLE.
